// File: rtl/vga_line_fetcher.sv
// Scanline requester for the SRAM driver's VGA burst port.
// One burst per line_start fills the back half of a ping-pong line buffer.
module vga_line_fetcher #(
  parameter int          LINE_WORDS = 320,
  parameter int          NUM_LINES  = 240,
  parameter logic [18:0] FB_BASE    = 19'h00000
) (
  input  logic        clk_50mhz,
  input  logic        reset,
  input  logic        line_start,
  input  logic [8:0]  line_num,
  output logic        vga_burst_req,
  input  logic        vga_burst_ack,
  output logic [18:0] vga_burst_addr,
  output logic [8:0]  vga_burst_len,
  input  logic        vga_wdata_valid,
  input  logic [15:0] vga_wdata,
  input  logic [8:0]  pix_addr,
  output logic [15:0] pix_data,
  output logic        fetch_busy,
  output logic        underrun,
  output logic        len_err,
  input  logic        err_clr
);

  localparam int         DEPTH = 2 * LINE_WORDS;
  localparam int         AW    = $clog2(DEPTH);
  localparam logic [8:0] LEN   = 9'(LINE_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_FILL    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t         state_r;
  logic [8:0]     line_r;
  logic [8:0]     wr_ptr_r;
  logic           disp_bank_r;
  logic           req_r;
  logic [18:0]    addr_r;
  logic           busy_r;
  logic           underrun_r;
  logic           len_err_r;
  logic [15:0]    pix_data_r;

  logic [15:0]    line_buf [DEPTH];

  logic           in_fill_s;
  logic           wr_en_s;
  logic [9:0]     count_s;
  logic           len_evt_s;
  logic           underrun_evt_s;
  logic [AW-1:0]  wr_addr_s;
  logic [AW-1:0]  rd_addr_s;
  logic           rd_in_range_s;
  logic [8:0]     line_clamp_s;
  logic [18:0]    addr_calc_s;

  // Write/read address decode, error events and burst address arithmetic
  always_comb begin
    in_fill_s      = 1'b0;
    wr_en_s        = 1'b0;
    count_s        = 10'd0;
    len_evt_s      = 1'b0;
    underrun_evt_s = 1'b0;
    wr_addr_s      = '0;
    rd_addr_s      = '0;
    rd_in_range_s  = 1'b0;
    line_clamp_s   = 9'd0;
    addr_calc_s    = 19'd0;

    in_fill_s = (state_r == ST_FILL);
    if (in_fill_s && vga_wdata_valid && (wr_ptr_r < LEN) && !reset) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end

    // The word arriving with ack is counted before the length compare.
    count_s = {1'b0, wr_ptr_r} + (wr_en_s ? 10'd1 : 10'd0);

    if (vga_wdata_valid && !wr_en_s) begin
      len_evt_s = 1'b1;
    end else if (in_fill_s && vga_burst_ack && (count_s != {1'b0, LEN})) begin
      len_evt_s = 1'b1;
    end else begin
      len_evt_s = 1'b0;
    end

    underrun_evt_s = line_start && busy_r;

    // Write bank is always the bank not on display.
    if (disp_bank_r) begin
      wr_addr_s = AW'(wr_ptr_r);
      rd_addr_s = AW'(LINE_WORDS) + AW'(pix_addr);
    end else begin
      wr_addr_s = AW'(LINE_WORDS) + AW'(wr_ptr_r);
      rd_addr_s = AW'(pix_addr);
    end
    rd_in_range_s = (pix_addr < LEN);

    if ({23'd0, line_num} >= 32'(NUM_LINES)) begin
      line_clamp_s = 9'd0;
    end else begin
      line_clamp_s = line_num;
    end

    addr_calc_s = FB_BASE + (19'(line_r) * 19'(LINE_WORDS));
  end

  // Burst handshake sequencer: IDLE -> REQ -> FILL -> RELEASE
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      line_r      <= 9'd0;
      wr_ptr_r    <= 9'd0;
      disp_bank_r <= 1'b0;
      req_r       <= 1'b0;
      addr_r      <= 19'd0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (line_start) begin
            line_r      <= line_clamp_s;
            busy_r      <= 1'b1;
            disp_bank_r <= ~disp_bank_r;
            state_r     <= ST_REQ;
          end
        end
        ST_REQ: begin
          addr_r  <= addr_calc_s;
          req_r   <= 1'b1;
          state_r <= ST_FILL;
        end
        ST_FILL: begin
          if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + 9'd1;
          end
          if (vga_burst_ack) begin
            req_r   <= 1'b0;
            state_r <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!vga_burst_ack) begin
            wr_ptr_r <= 9'd0;
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          req_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a new event outranks a simultaneous clear
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      underrun_r <= 1'b0;
      len_err_r  <= 1'b0;
    end else begin
      if (underrun_evt_s) begin
        underrun_r <= 1'b1;
      end else if (err_clr) begin
        underrun_r <= 1'b0;
      end
      if (len_evt_s) begin
        len_err_r <= 1'b1;
      end else if (err_clr) begin
        len_err_r <= 1'b0;
      end
    end
  end

  // Line buffer write port (contents survive reset)
  always_ff @(posedge clk_50mhz) begin
    if (wr_en_s) begin
      line_buf[wr_addr_s] <= vga_wdata;
    end
  end

  // Registered scanout read port
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      pix_data_r <= 16'd0;
    end else if (rd_in_range_s) begin
      pix_data_r <= line_buf[rd_addr_s];
    end else begin
      pix_data_r <= 16'd0;
    end
  end

  assign vga_burst_req  = req_r;
  assign vga_burst_addr = addr_r;
  assign vga_burst_len  = LEN;
  assign pix_data       = pix_data_r;
  assign fetch_busy     = busy_r;
  assign underrun       = underrun_r;
  assign len_err        = len_err_r;

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Bench for vga_line_fetcher: fetch table, randomized fetches against a
// bank-array reference model, plus reset/error corner sequences.
module tb_vga_line_fetcher;

  localparam int          LW   = 320;
  localparam int          NL   = 240;
  localparam logic [18:0] BASE = 19'h00000;

  logic clk_50mhz = 1'b0;
  always #10 clk_50mhz = ~clk_50mhz;

  logic        reset = 1'b1;
  logic        line_start = 1'b0;
  logic [8:0]  line_num = 9'd0;
  logic        vga_burst_req;
  logic        vga_burst_ack = 1'b0;
  logic [18:0] vga_burst_addr;
  logic [8:0]  vga_burst_len;
  logic        vga_wdata_valid = 1'b0;
  logic [15:0] vga_wdata = 16'd0;
  logic [8:0]  pix_addr = 9'd0;
  logic [15:0] pix_data;
  logic        fetch_busy;
  logic        underrun;
  logic        len_err;
  logic        err_clr = 1'b0;

  logic        b_reset = 1'b1;
  logic        b_line_start = 1'b0;
  logic [8:0]  b_line_num = 9'd0;
  logic        b_req;
  logic [18:0] b_addr;
  logic [8:0]  b_len;
  logic [15:0] b_pix_data;
  logic        b_busy;
  logic        b_underrun;
  logic        b_len_err;

  vga_line_fetcher #(.LINE_WORDS(LW), .NUM_LINES(NL), .FB_BASE(BASE)) dut (
    .clk_50mhz(clk_50mhz), .reset(reset), .line_start(line_start), .line_num(line_num),
    .vga_burst_req(vga_burst_req), .vga_burst_ack(vga_burst_ack),
    .vga_burst_addr(vga_burst_addr), .vga_burst_len(vga_burst_len),
    .vga_wdata_valid(vga_wdata_valid), .vga_wdata(vga_wdata), .pix_addr(pix_addr),
    .pix_data(pix_data), .fetch_busy(fetch_busy), .underrun(underrun),
    .len_err(len_err), .err_clr(err_clr)
  );

  // Second instance near the top of the address space; its driver acks immediately.
  vga_line_fetcher #(.LINE_WORDS(LW), .NUM_LINES(NL), .FB_BASE(19'h7FF00)) dut_b (
    .clk_50mhz(clk_50mhz), .reset(b_reset), .line_start(b_line_start), .line_num(b_line_num),
    .vga_burst_req(b_req), .vga_burst_ack(b_req),
    .vga_burst_addr(b_addr), .vga_burst_len(b_len),
    .vga_wdata_valid(1'b0), .vga_wdata(16'd0), .pix_addr(9'd0),
    .pix_data(b_pix_data), .fetch_busy(b_busy), .underrun(b_underrun),
    .len_err(b_len_err), .err_clr(1'b0)
  );

  // Reference model: two line banks, which one is displayed, and the error flags.
  logic [15:0] mm [2][LW];
  bit          mv [2][LW];
  bit          m_disp = 1'b0;
  bit          m_underrun = 1'b0;
  bit          m_len_err = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [8:0]  line;
    int          nwords;
    bit          ack_last;
    bit          inject;
    logic [18:0] addr;
    bit          len_err;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [18:0] exp_addr(input logic [18:0] base, input int line);
    int l;
    l = (line >= NL) ? 0 : line;
    return 19'((int'(base) + l * LW) % 524288);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic sweep();
    for (int a = 0; a <= LW; a++) begin
      pix_addr = 9'(a);
      tick();
      if (a >= LW) check("pix_oor", 32'(pix_data), 32'd0);
      else if (mv[m_disp][a]) check("pix_data", 32'(pix_data), 32'(mm[m_disp][a]));
    end
    pix_addr = 9'd511;
    tick();
    check("pix_oor_511", 32'(pix_data), 32'd0);
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_underrun = 1'b0;
    m_len_err = 1'b0;
    check("err_clr", {30'd0, underrun, len_err}, 32'd0);
  endtask

  task automatic run_fetch(input logic [8:0] line, input int nwords, input bit ack_last,
                           input bit inject, input bit pattern, output logic [18:0] got_addr);
    int          ra;
    int          wb;
    int          n;
    logic [15:0] pre;
    bit          pre_ok;
    logic [15:0] d;
    ra = int'($urandom_range(LW - 1));
    pre = mm[m_disp][ra];
    pre_ok = mv[m_disp][ra];
    pix_addr = 9'(ra);
    line_num = line;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    if (pre_ok) check("swap_read", 32'(pix_data), 32'(pre));
    m_disp = ~m_disp;
    wb = m_disp ? 0 : 1;
    check("busy_set", 32'(fetch_busy), 32'd1);
    check("req_early", 32'(vga_burst_req), 32'd0);
    tick();
    check("req", 32'(vga_burst_req), 32'd1);
    check("addr", 32'(vga_burst_addr), 32'(exp_addr(BASE, int'(line))));
    check("len", 32'(vga_burst_len), 32'(LW));
    got_addr = vga_burst_addr;
    if (inject) begin
      line_num = 9'd7;
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      m_underrun = 1'b1;
      check("underrun", 32'(underrun), 32'd1);
      check("addr_hold", 32'(vga_burst_addr), 32'(exp_addr(BASE, int'(line))));
      check("busy_hold", 32'(fetch_busy), 32'd1);
    end
    for (int i = 0; i < nwords; i++) begin
      d = pattern ? (16'(i) ^ 16'hA5A5) : 16'($urandom);
      vga_wdata_valid = 1'b1;
      vga_wdata = d;
      if (ack_last && i == nwords - 1) vga_burst_ack = 1'b1;
      if (i < LW) begin
        mm[wb][i] = d;
        mv[wb][i] = 1'b1;
      end
      tick();
    end
    vga_wdata_valid = 1'b0;
    vga_burst_ack = 1'b1;
    if (nwords != LW) m_len_err = 1'b1;
    for (n = 0; n < 20 && vga_burst_req; n++) tick();
    check("req_drop", 32'(vga_burst_req), 32'd0);
    vga_burst_ack = 1'b0;
    tick();
    check("busy_clr", 32'(fetch_busy), 32'd0);
    check("len_err", 32'(len_err), 32'(m_len_err));
    check("underrun_flag", 32'(underrun), 32'(m_underrun));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [18:0] got;
    int          wb;
    logic [15:0] d;

    tbl[0] = '{9'd5,   320, 1'b1, 1'b0, 19'd1600,  1'b0};
    tbl[1] = '{9'd100, 320, 1'b0, 1'b0, 19'd32000, 1'b0};
    tbl[2] = '{9'd239, 319, 1'b0, 1'b0, 19'd76480, 1'b1};
    tbl[3] = '{9'd300, 321, 1'b1, 1'b0, 19'd0,     1'b1};
    tbl[4] = '{9'd511, 320, 1'b0, 1'b1, 19'd0,     1'b0};
    tbl[5] = '{9'd1,   320, 1'b1, 1'b0, 19'd320,   1'b0};

    tick();
    tick();
    check("rst_req", 32'(vga_burst_req), 32'd0);
    check("rst_addr", 32'(vga_burst_addr), 32'd0);
    check("rst_pix", 32'(pix_data), 32'd0);
    check("rst_busy", 32'(fetch_busy), 32'd0);
    check("rst_flags", {30'd0, underrun, len_err}, 32'd0);
    reset = 1'b0;
    b_reset = 1'b0;
    tick();

    for (int k = 0; k < 6; k++) begin
      run_fetch(tbl[k].line, tbl[k].nwords, tbl[k].ack_last, tbl[k].inject, 1'b1, got);
      check("tbl_addr", 32'(got), 32'(tbl[k].addr));
      check("tbl_len_err", 32'(len_err), 32'(tbl[k].len_err));
      check("tbl_underrun", 32'(underrun), 32'(tbl[k].inject));
      sweep();
      clear_errors();
    end

    // Data strobe while idle, then strobe coinciding with err_clr.
    vga_wdata_valid = 1'b1;
    tick();
    vga_wdata_valid = 1'b0;
    check("idle_valid", 32'(len_err), 32'd1);
    clear_errors();
    vga_wdata_valid = 1'b1;
    err_clr = 1'b1;
    tick();
    vga_wdata_valid = 1'b0;
    err_clr = 1'b0;
    check("evt_beats_clr", 32'(len_err), 32'd1);
    clear_errors();

    for (int r = 0; r < 8; r++) begin
      run_fetch(9'($urandom_range(511)), LW - 1 + int'($urandom_range(2)),
                1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, got);
      sweep();
      clear_errors();
    end

    // Reset in the middle of a fill.
    line_num = 9'd20;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    m_disp = ~m_disp;
    wb = m_disp ? 0 : 1;
    tick();
    check("mid_req", 32'(vga_burst_req), 32'd1);
    for (int i = 0; i < 100; i++) begin
      d = 16'($urandom);
      vga_wdata_valid = 1'b1;
      vga_wdata = d;
      mm[wb][i] = d;
      mv[wb][i] = 1'b1;
      tick();
    end
    vga_wdata_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("mid_rst_req", 32'(vga_burst_req), 32'd0);
    check("mid_rst_busy", 32'(fetch_busy), 32'd0);
    check("mid_rst_pix", 32'(pix_data), 32'd0);
    reset = 1'b0;
    m_disp = 1'b0;
    m_underrun = 1'b0;
    m_len_err = 1'b0;
    tick();
    run_fetch(9'd21, LW, 1'b1, 1'b0, 1'b0, got);
    run_fetch(9'd22, LW, 1'b0, 1'b0, 1'b1, got);
    sweep();

    // Address wrap and clamp on the high-base instance.
    b_line_num = 9'd1;
    b_line_start = 1'b1;
    tick();
    b_line_start = 1'b0;
    tick();
    check("b_req", 32'(b_req), 32'd1);
    check("b_wrap_addr", 32'(b_addr), 32'h00040);
    for (int n = 0; n < 20 && b_busy; n++) tick();
    check("b_idle", 32'(b_busy), 32'd0);
    b_line_num = 9'd300;
    b_line_start = 1'b1;
    tick();
    b_line_start = 1'b0;
    tick();
    check("b_clamp_addr", 32'(b_addr), 32'h7FF00);
    check("b_len", 32'(b_len), 32'(LW));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
